// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared types, constants and round-robin pick helper for the ALU share arbiter
package alu_share_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int SEL_W_DEF = 4;

    localparam logic [SEL_W_DEF-1:0] ALU_SEL_ADD = 4'b0000;

    typedef struct packed {
        logic [SEL_W_DEF-1:0] sel;
        logic [XLEN_DEF-1:0]  a;
        logic [XLEN_DEF-1:0]  b;
    } alu_req_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid[0..n-1] scanning upward from ptr with wrap; n <= 8.
    function automatic rr_pick_t rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
        rr_pick_t    r;
        logic [3:0]  j;
        r = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            j = {1'b0, ptr} + k[3:0];
            if (j >= 4'(n)) begin
                j = j - 4'(n);
            end
            if (k < n && !r.found && valid[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// rtl/alu_share_arbiter_rr.sv - round-robin one-hot grant with pointer advancing on grant
module rr_arbiter
    import alu_share_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   i_valid,
    input  logic           i_en,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_take
);

    generate
        if (N < 2 || N > 8) begin : g_bad_n
            $error("rr_arbiter: N must be in 2..8");
        end
    endgenerate

    logic [IDW-1:0] r_ptr;
    rr_pick_t       w_pick;
    logic [IDW-1:0] w_next;

    always_comb begin
        w_pick  = rr_pick(8'(i_valid), 3'(r_ptr), N);
        o_idx   = IDW'(w_pick.idx);
        o_take  = i_en & w_pick.found;
        o_grant = '0;
        if (o_take) begin
            o_grant[o_idx] = 1'b1;
        end
        w_next = (int'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_take) begin
            r_ptr <= w_next;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - time-shares one combinational ALU between requesters via issue and response stages
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int XLEN    = XLEN_DEF,
    parameter  int SEL_W   = SEL_W_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*SEL_W-1:0] req_sel,
    input  logic [NUM_REQ*XLEN-1:0]  req_a,
    input  logic [NUM_REQ*XLEN-1:0]  req_b,
    output logic [SEL_W-1:0]         alu_sel,
    output logic [XLEN-1:0]          alu_reg1,
    output logic [XLEN-1:0]          alu_reg2,
    input  logic [XLEN-1:0]          alu_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [XLEN-1:0]          rsp_data,
    output logic                     busy
);

    logic             r_s1_v;
    logic [ID_W-1:0]  r_s1_id;
    logic [SEL_W-1:0] r_alu_sel;
    logic [XLEN-1:0]  r_alu_reg1;
    logic [XLEN-1:0]  r_alu_reg2;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [XLEN-1:0]  r_rsp_data;

    logic             w_s2_en;
    logic             w_s1_en;
    logic             w_take;
    logic [ID_W-1:0]  w_idx;

    assign w_s2_en = !r_rsp_valid | rsp_ready;
    assign w_s1_en = !r_s1_v | w_s2_en;

    // Reset gates the grant so nothing is accepted on the reset edge.
    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_valid (req_valid),
        .i_en    (w_s1_en & !rst),
        .o_grant (req_ready),
        .o_idx   (w_idx),
        .o_take  (w_take)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s1_id    <= '0;
            r_alu_sel  <= '0;
            r_alu_reg1 <= '0;
            r_alu_reg2 <= '0;
        end else if (w_s1_en) begin
            r_s1_v <= w_take;
            if (w_take) begin
                r_s1_id    <= w_idx;
                r_alu_sel  <= req_sel[w_idx*SEL_W +: SEL_W];
                r_alu_reg1 <= req_a[w_idx*XLEN +: XLEN];
                r_alu_reg2 <= req_b[w_idx*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else if (w_s2_en) begin
            r_rsp_valid <= r_s1_v;
            if (r_s1_v) begin
                r_rsp_id   <= r_s1_id;
                r_rsp_data <= alu_out;
            end
        end
    end

    assign alu_sel   = r_alu_sel;
    assign alu_reg1  = r_alu_reg1;
    assign alu_reg2  = r_alu_reg2;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_s1_v | r_rsp_valid;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int NR = 4;
    localparam int XW = 32;
    localparam int SW = 4;
    localparam logic [SW-1:0] SEL_SUB = 4'b1000;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR*SW-1:0] req_sel;
    logic [NR*XW-1:0] req_a;
    logic [NR*XW-1:0] req_b;
    logic [SW-1:0]  alu_sel;
    logic [XW-1:0]  alu_reg1;
    logic [XW-1:0]  alu_reg2;
    logic [XW-1:0]  alu_out;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [XW-1:0]  rsp_data;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XW-1:0] exp_sum [4];

    alu_share_arbiter #(.NUM_REQ(NR), .XLEN(XW), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_sel   (alu_sel),
        .alu_reg1  (alu_reg1),
        .alu_reg2  (alu_reg2),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_out = alu_reg1 ^ alu_reg2;
        if (alu_sel == ALU_SEL_ADD) alu_out = alu_reg1 + alu_reg2;
        else if (alu_sel == SEL_SUB) alu_out = alu_reg1 - alu_reg2;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [SW-1:0] s, input logic [XW-1:0] a, input logic [XW-1:0] b);
        req_sel[i*SW +: SW] = s;
        req_a[i*XW +: XW]   = a;
        req_b[i*XW +: XW]   = b;
    endtask

    // Requester-side hold rule: fields stay stable while valid and not ready.
    logic [NR-1:0]    p_v = '0;
    logic [NR-1:0]    p_r = '0;
    logic             p_rst = 1'b1;
    logic [NR*SW-1:0] p_s = '0;
    logic [NR*XW-1:0] p_a = '0;
    logic [NR*XW-1:0] p_b = '0;
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (!p_rst && p_v[i] && !p_r[i] && req_valid[i]) begin
                check($sformatf("hold_a%0d", i), 64'(req_a[i*XW +: XW]), 64'(p_a[i*XW +: XW]));
                check($sformatf("hold_b%0d", i), 64'(req_b[i*XW +: XW]), 64'(p_b[i*XW +: XW]));
                check($sformatf("hold_s%0d", i), 64'(req_sel[i*SW +: SW]), 64'(p_s[i*SW +: SW]));
            end
        end
        p_v   <= req_valid;
        p_r   <= req_ready;
        p_rst <= rst;
        p_s   <= req_sel;
        p_a   <= req_a;
        p_b   <= req_b;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        req_sel = '0; req_a = '0; req_b = '0;

        // reset state, req_ready low during the reset cycle
        step();
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_reg1", 64'(alu_reg1), 64'h0);
        check("rst_ptr", 64'(dut.u_rr.r_ptr), 64'h0);
        rst = 1'b0; req_valid = '0;

        // single requester 0: 1 + 1
        step();
        set_req(0, ALU_SEL_ADD, 32'd1, 32'd1);
        req_valid = 4'b0001;
        #1 check("t1_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        #1;
        check("t1_reg1", 64'(alu_reg1), 64'h1);
        check("t1_reg2", 64'(alu_reg2), 64'h1);
        check("t1_sel", 64'(alu_sel), 64'h0);
        check("t1_early_rsp", 64'(rsp_valid), 64'h0);
        check("t1_busy", 64'(busy), 64'h1);
        step();
        check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t1_rsp_id", 64'(rsp_id), 64'h0);
        check("t1_rsp_data", 64'(rsp_data), 64'h2);
        step();
        check("t1_rsp_done", 64'(rsp_valid), 64'h0);
        check("t1_idle", 64'(busy), 64'h0);
        check("t1_ptr", 64'(dut.u_rr.r_ptr), 64'h1);

        // all four requesting from rr_ptr = 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, ALU_SEL_ADD, 32'd0, 32'd1);
        set_req(1, ALU_SEL_ADD, 32'd1, 32'd22);
        set_req(2, ALU_SEL_ADD, 32'd5, 32'd5);
        set_req(3, ALU_SEL_ADD, 32'd7, 32'd0);
        exp_sum[0] = 32'd1; exp_sum[1] = 32'd23; exp_sum[2] = 32'd10; exp_sum[3] = 32'd7;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("t2_grant%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
            if (k >= 2) begin
                check($sformatf("t2_rv%0d", k), 64'(rsp_valid), 64'h1);
                check($sformatf("t2_id%0d", k), 64'(rsp_id), 64'((k - 2) % 4));
                check($sformatf("t2_data%0d", k), 64'(rsp_data), 64'(exp_sum[(k - 2) % 4]));
            end
            step();
        end

        // requesters 1 and 3 with rr_ptr = 2
        req_valid = 4'b0010;
        #1 check("t3_prime", 64'(req_ready), 64'h2);
        step();
        req_valid = 4'b1010;
        #1 check("t3_g3a", 64'(req_ready), 64'h8);
        step();
        #1;
        check("t3_g1a", 64'(req_ready), 64'h2);
        check("t3_rsp_id", 64'(rsp_id), 64'h1);
        check("t3_rsp_data", 64'(rsp_data), 64'd23);
        step();
        #1;
        check("t3_ptr", 64'(dut.u_rr.r_ptr), 64'h2);
        check("t3_g3b", 64'(req_ready), 64'h8);
        step();
        #1 check("t3_g1b", 64'(req_ready), 64'h2);
        step();
        req_valid = '0;
        step(); step(); step();

        // backpressure: rsp_ready low for three cycles, rr_ptr = 2
        set_req(0, ALU_SEL_ADD, 32'hFFFF_FFFF, 32'd1);
        set_req(1, ALU_SEL_ADD, 32'd2, 32'd3);
        set_req(2, ALU_SEL_ADD, 32'd10, 32'd20);
        set_req(3, ALU_SEL_ADD, 32'd100, 32'd1);
        req_valid = 4'b1111; rsp_ready = 1'b0;
        #1;
        check("t4_c0_ready", 64'(req_ready), 64'h4);
        check("t4_c0_rv", 64'(rsp_valid), 64'h0);
        step();
        #1 check("t4_c1_ready", 64'(req_ready), 64'h8);
        step();
        #1;
        check("t4_c2_ready", 64'(req_ready), 64'h0);
        check("t4_c2_rv", 64'(rsp_valid), 64'h1);
        check("t4_c2_id", 64'(rsp_id), 64'h2);
        check("t4_c2_data", 64'(rsp_data), 64'd30);
        step();
        rsp_ready = 1'b1;
        #1;
        check("t4_c3_ready", 64'(req_ready), 64'h1);
        check("t4_c3_id", 64'(rsp_id), 64'h2);
        check("t4_c3_data", 64'(rsp_data), 64'd30);
        step();
        #1;
        check("t4_c4_ready", 64'(req_ready), 64'h2);
        check("t4_c4_id", 64'(rsp_id), 64'h3);
        check("t4_c4_data", 64'(rsp_data), 64'd101);
        step();
        req_valid = '0;
        #1;
        check("t4_c5_id", 64'(rsp_id), 64'h0);
        check("t4_c5_wrap", 64'(rsp_data), 64'h0);
        step();
        #1;
        check("t4_c6_id", 64'(rsp_id), 64'h1);
        check("t4_c6_data", 64'(rsp_data), 64'd5);
        step();
        #1 check("t4_c7_rv", 64'(rsp_valid), 64'h0);

        // reset while S1 and S2 both hold work
        set_req(2, ALU_SEL_ADD, 32'd3, 32'd4);
        req_valid = 4'b0100;
        step();
        step();
        rst = 1'b1;
        #1;
        check("t5_pre_rv", 64'(rsp_valid), 64'h1);
        check("t5_rst_ready", 64'(req_ready), 64'h0);
        step();
        rst = 1'b0; req_valid = '0;
        #1;
        check("t5_rv", 64'(rsp_valid), 64'h0);
        check("t5_busy", 64'(busy), 64'h0);
        check("t5_ptr", 64'(dut.u_rr.r_ptr), 64'h0);
        check("t5_reg1", 64'(alu_reg1), 64'h0);
        check("t5_reg2", 64'(alu_reg2), 64'h0);
        check("t5_sel", 64'(alu_sel), 64'h0);
        check("t5_data", 64'(rsp_data), 64'h0);
        step();
        #1 check("t5_no_stale", 64'(rsp_valid), 64'h0);

        // opaque sel, then idle gap
        set_req(0, SEL_SUB, 32'd9, 32'd4);
        req_valid = 4'b0001;
        #1 check("t6_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        #1;
        check("t6_busy1", 64'(busy), 64'h1);
        check("t6_sel", 64'(alu_sel), 64'(SEL_SUB));
        step();
        #1;
        check("t6_rv", 64'(rsp_valid), 64'h1);
        check("t6_data", 64'(rsp_data), 64'd5);
        step();
        #1;
        check("t6_busy0", 64'(busy), 64'h0);
        check("t6_hold_reg1", 64'(alu_reg1), 64'd9);
        check("t6_hold_reg2", 64'(alu_reg2), 64'd4);
        check("t6_hold_sel", 64'(alu_sel), 64'(SEL_SUB));
        req_valid = 4'b0010;
        #1 check("t6_idle_ready", 64'(req_ready), 64'h2);
        req_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Time-shares the single combinational RV32I ALU between NUM_REQ requesters, such as an R-type issue path plus auxiliary units like address generation and a debug port. Arbitration is round-robin with a per-requester valid/ready handshake. The block drives the ALU operand and select inputs from a registered issue stage and captures ALU_Out into a registered response stage. The response carries the requester ID and supports backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
XLEN, 32, operand/result width
SEL_W, 4, ALU_sel width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_sel  in  NUM_REQ*SEL_W  per-requester ALU_sel, packed, requester i at [i*SEL_W +: SEL_W]
req_a  in  NUM_REQ*XLEN  per-requester reg1 operand, packed
req_b  in  NUM_REQ*XLEN  per-requester reg2 operand, packed
alu_sel  out  SEL_W  to ALU ALU_sel (registered)
alu_reg1  out  XLEN  to ALU reg1 (registered)
alu_reg2  out  XLEN  to ALU reg2 (registered)
alu_out  in  XLEN  from ALU ALU_Out (combinational from above)
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_id  out  $clog2(NUM_REQ)  requester index of result
rsp_data  out  XLEN  captured ALU result
busy  out  1  s1_v | rsp_valid

Behaviour:
- Pipeline: S1 (issue regs: s1_v, s1_id, alu_sel/reg1/reg2) -> S2 (rsp regs: rsp_valid, rsp_id, rsp_data).
- s2_en = !rsp_valid | rsp_ready.
- s1_en = !s1_v | s2_en.
- Transfer on req_valid[i] & req_ready[i] (same rising edge). Transfer on rsp_valid & rsp_ready.
- Grant is combinational. Scan req_valid starting at rr_ptr, ascending with wrap, and take the first set bit g. Then req_ready = s1_en ? onehot(g) : 0.
- req_ready never depends on req_valid of other requesters beyond the RR scan. No combinational path from rsp_ready to alu_* outputs.
- On grant at edge T:
  - s1_v <= 1, s1_id <= g, alu_* <= requester g's fields.
  - rr_ptr <= (g+1) mod NUM_REQ.
- If s1_en and no grant: s1_v <= 0. alu_* hold their last value (no toggling).
- If s2_en: rsp_valid <= s1_v. When s1_v is set, also rsp_id <= s1_id and rsp_data <= alu_out.
- While !s2_en, S2 holds. While !s1_en, S1 holds, req_ready = 0 and rr_ptr holds.
- Latency: accept at edge T -> rsp_valid high after edge T+1, i.e. 2 edges with rsp_ready = 1.
- Throughput: 1 result/cycle sustained.
- Fairness: any continuously asserted requester is granted within NUM_REQ grants.
- rr_ptr advances only on a grant.
- alu_sel is passed through opaquely; the block never decodes it.
- Width rule: rsp_data = alu_out exactly, XLEN bits, no extension.
- Reset (sync, wins over all activity): s1_v = 0, rsp_valid = 0, rr_ptr = 0, alu_sel/reg1/reg2 = 0, rsp_id = 0, rsp_data = 0, req_ready = 0 during the rst cycle.
- Reset mid-operation drops in-flight S1/S2 contents with no response.
- Requester must hold req_* stable while valid & !ready. This is not checked in RTL; it is a bench assertion.
- NUM_REQ = 1 is not supported (elaboration error).

Decomposition:
- Package alu_share_pkg holds:
  - XLEN_DEF = 32, SEL_W_DEF = 4
  - ALU_SEL_ADD = 4'b0000
  - typedef alu_req_t {sel, a, b}
  - function rr_pick(valid, ptr) returning index and found flag
- Natural sub-module: rr_arbiter, the parameterised round-robin one-hot grant with pointer register and advance-on-grant input.
- Top holds both pipeline stages only.

Test Plan:
- Single requester 0, ADD (sel 0000), a = 1, b = 1, rsp_ready = 1 -> rsp_valid 2 edges after accept, rsp_id = 0, rsp_data = 2.
- Requesters 0..3 all valid every cycle, each with ADD: (0,1), (1,22), (5,5), (7,0) -> grants in order 0,1,2,3,0...; responses 1, 23, 10, 7 back-to-back, one per cycle, IDs match.
- Requesters 1 and 3 valid, rr_ptr = 2 -> grant 3 first, then 1; then rr_ptr = 2 again and the pattern repeats.
- rsp_ready held 0 for 3 cycles with continuous requests:
  - S2 holds, S1 fills, then req_ready = 0 everywhere.
  - No data lost or duplicated after release; 0xFFFFFFFF + 1 (ADD) returns 0x00000000.
- Assert rst for one cycle while S1 and S2 are both valid -> next cycle rsp_valid = 0, busy = 0, rr_ptr = 0, alu_reg1/reg2/sel = 0. The stale response never appears.
- Idle gap after traffic -> alu_reg1/reg2/sel hold their last values, req_ready follows s1_en, and busy deasserts 2 cycles after the last accept.
